// File: rtl/confirm_queue_if.sv
// Handshake bundle for confirm_queue: station-ID input side and one-hot confirm output side.
interface confirm_queue_if #(
  parameter int unsigned N_RS  = 8,
  parameter int unsigned ID_W  = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            id_valid;
  logic [ID_W-1:0] id_in;
  logic            id_ready;
  logic [N_RS-1:0] confirma;
  logic            conf_valid;
  logic            ack;
  logic [CntW-1:0] count;
  logic            bad_id;

  modport slave (
    input  id_valid, id_in, ack,
    output id_ready, confirma, conf_valid, count, bad_id
  );

  modport master (
    output id_valid, id_in, ack,
    input  id_ready, confirma, conf_valid, count, bad_id
  );
endinterface

// File: rtl/confirm_queue.sv
// Queues reservation-station IDs and presents them one at a time as a registered one-hot
// confirm, held until the addressed station acks; empty-queue IDs bypass straight to output.
module confirm_queue #(
  parameter int unsigned N_RS  = 8,
  parameter int unsigned ID_W  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic            CLK,
  input  logic            CLR,
  confirm_queue_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle = 1'b0, StHold = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [N_RS-1:0]   confirma_q, confirma_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              bad_id_q, bad_id_d;
  logic [ID_W-1:0]   mem_q [DEPTH];
  logic [ID_W-1:0]   mem_d [DEPTH];

  logic id_ready;
  logic push_fire, legal, pop, bypass, store;

  function automatic logic [N_RS-1:0] to_onehot(input logic [ID_W-1:0] id);
    logic [N_RS-1:0] oh;
    for (int i = 0; i < N_RS; i++) begin
      oh[i] = (id == ID_W'(i + 1));
    end
    return oh;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Readiness comes from registered occupancy only, so a full queue never passes through on ack.
  assign id_ready  = (count_q < CntW'(DEPTH));
  assign push_fire = bus.id_valid & id_ready;
  assign legal     = (bus.id_in != '0) && (bus.id_in <= ID_W'(N_RS));

  always_comb begin
    state_d    = state_q;
    confirma_d = confirma_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    bad_id_d   = push_fire & ~legal;
    pop        = 1'b0;
    bypass     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop = 1'b1;
        end else if (push_fire && legal) begin
          bypass = 1'b1;
        end
      end
      StHold: begin
        if (bus.ack) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else if (push_fire && legal) begin
            bypass = 1'b1;
          end else begin
            state_d    = StIdle;
            confirma_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    store = push_fire & legal & ~bypass;

    if (pop) begin
      confirma_d = to_onehot(mem_q[rd_ptr_q]);
      state_d    = StHold;
      rd_ptr_d   = ptr_inc(rd_ptr_q);
    end
    if (bypass) begin
      confirma_d = to_onehot(bus.id_in);
      state_d    = StHold;
    end
    if (store) begin
      mem_d[wr_ptr_q] = bus.id_in;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    if (store && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !store) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= StIdle;
      confirma_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bad_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      confirma_q <= confirma_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bad_id_q   <= bad_id_d;
    end
  end

  // Storage is unreset; stale entries are unreachable because count gates every read.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign bus.id_ready   = id_ready;
  assign bus.confirma   = confirma_q;
  assign bus.conf_valid = (state_q == StHold);
  assign bus.count      = count_q;
  assign bus.bad_id     = bad_id_q;
endmodule

// File: tb/tb_confirm_queue.sv
// Directed bench for confirm_queue (N_RS=8, ID_W=4, DEPTH=4) with hand-computed expectations.
module tb_confirm_queue;
  logic CLK = 1'b0;
  logic CLR;
  int   compared = 0;
  int   mismatched = 0;

  confirm_queue_if #(.N_RS(8), .ID_W(4), .DEPTH(4)) bus ();

  confirm_queue #(.N_RS(8), .ID_W(4), .DEPTH(4)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks confirm, valid and occupancy together.
  task automatic chk_out(input string tag, input logic [7:0] cf, input logic cv,
                         input logic [2:0] cnt);
    chk({tag, ".confirma"}, 32'(bus.confirma), 32'(cf));
    chk({tag, ".conf_valid"}, 32'(bus.conf_valid), 32'(cv));
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] id, input logic a);
    bus.id_valid = v;
    bus.id_in    = id;
    bus.ack      = a;
  endtask

  initial begin
    CLR = 1'b1;
    drive(1'b0, 4'd0, 1'b0);
    #3;
    chk_out("reset", 8'h00, 1'b0, 3'd0);
    chk("reset.bad_id", 32'(bus.bad_id), 32'd0);
    chk("reset.id_ready", 32'(bus.id_ready), 32'd1);
    #20;
    CLR = 1'b0;
    cyc();

    // Bypass from empty, held until ack
    drive(1'b1, 4'd3, 1'b0);
    cyc();
    chk_out("bypass", 8'h04, 1'b1, 3'd0);
    drive(1'b0, 4'd0, 1'b0);
    cyc();
    cyc();
    chk_out("bypass_hold", 8'h04, 1'b1, 3'd0);
    drive(1'b0, 4'd0, 1'b1);
    cyc();
    chk_out("bypass_ack", 8'h00, 1'b0, 3'd0);

    // Back-to-back pushes with ack high: no bubbles
    drive(1'b1, 4'd7, 1'b1);
    cyc();
    chk_out("b2b_7", 8'h40, 1'b1, 3'd0);
    drive(1'b1, 4'd1, 1'b1);
    cyc();
    chk_out("b2b_1", 8'h01, 1'b1, 3'd0);
    drive(1'b1, 4'd8, 1'b1);
    cyc();
    chk_out("b2b_8", 8'h80, 1'b1, 3'd0);
    drive(1'b0, 4'd0, 1'b1);
    cyc();
    chk_out("b2b_end", 8'h00, 1'b0, 3'd0);
    cyc();
    chk_out("idle_ack_ignored", 8'h00, 1'b0, 3'd0);

    // Fill the queue with ack low
    drive(1'b1, 4'd2, 1'b0);
    cyc();
    chk_out("fill_2", 8'h02, 1'b1, 3'd0);
    drive(1'b1, 4'd3, 1'b0);
    cyc();
    chk_out("fill_3", 8'h02, 1'b1, 3'd1);
    drive(1'b1, 4'd4, 1'b0);
    cyc();
    drive(1'b1, 4'd5, 1'b0);
    cyc();
    chk_out("fill_5", 8'h02, 1'b1, 3'd3);
    drive(1'b1, 4'd6, 1'b0);
    cyc();
    chk_out("full", 8'h02, 1'b1, 3'd4);
    chk("full.id_ready", 32'(bus.id_ready), 32'd0);
    drive(1'b1, 4'd7, 1'b0);
    cyc();
    chk_out("full_reject", 8'h02, 1'b1, 3'd4);
    drive(1'b0, 4'd0, 1'b1);
    cyc();
    chk_out("full_ack", 8'h04, 1'b1, 3'd3);
    chk("full_ack.id_ready", 32'(bus.id_ready), 32'd1);

    // Illegal IDs with three queued
    drive(1'b1, 4'd0, 1'b0);
    cyc();
    chk("bad0.bad_id", 32'(bus.bad_id), 32'd1);
    chk_out("bad0", 8'h04, 1'b1, 3'd3);
    drive(1'b0, 4'd0, 1'b0);
    cyc();
    chk("bad0_gap.bad_id", 32'(bus.bad_id), 32'd0);
    drive(1'b1, 4'd9, 1'b0);
    cyc();
    chk("bad9.bad_id", 32'(bus.bad_id), 32'd1);
    chk_out("bad9", 8'h04, 1'b1, 3'd3);
    drive(1'b0, 4'd0, 1'b0);
    cyc();
    chk("bad9_gap.bad_id", 32'(bus.bad_id), 32'd0);

    // Asynchronous reset between edges with three queued
    #3;
    CLR = 1'b1;
    #1;
    chk_out("async_clr", 8'h00, 1'b0, 3'd0);
    chk("async_clr.id_ready", 32'(bus.id_ready), 32'd1);
    #1;
    CLR = 1'b0;
    cyc();
    cyc();
    chk_out("post_clr", 8'h00, 1'b0, 3'd0);

    // FIFO order
    drive(1'b1, 4'd2, 1'b0);
    cyc();
    drive(1'b1, 4'd5, 1'b0);
    cyc();
    drive(1'b1, 4'd3, 1'b0);
    cyc();
    chk_out("order_load", 8'h02, 1'b1, 3'd2);
    drive(1'b0, 4'd0, 1'b1);
    cyc();
    chk_out("order_5", 8'h10, 1'b1, 3'd1);
    cyc();
    chk_out("order_3", 8'h04, 1'b1, 3'd0);
    cyc();
    chk_out("order_end", 8'h00, 1'b0, 3'd0);

    // Push and pop together at count=1
    drive(1'b1, 4'd1, 1'b0);
    cyc();
    drive(1'b1, 4'd4, 1'b0);
    cyc();
    chk_out("pp_pre", 8'h01, 1'b1, 3'd1);
    drive(1'b1, 4'd7, 1'b1);
    cyc();
    chk_out("pp_swap", 8'h08, 1'b1, 3'd1);
    drive(1'b0, 4'd0, 1'b1);
    cyc();
    chk_out("pp_7", 8'h40, 1'b1, 3'd0);

    // Write pointer wraps past DEPTH-1
    drive(1'b1, 4'd8, 1'b0);
    cyc();
    chk_out("wrap_push", 8'h40, 1'b1, 3'd1);
    drive(1'b0, 4'd0, 1'b1);
    cyc();
    chk_out("wrap_pop", 8'h80, 1'b1, 3'd0);
    cyc();
    chk_out("wrap_end", 8'h00, 1'b0, 3'd0);

    // Ack plus push with empty FIFO
    drive(1'b1, 4'd2, 1'b0);
    cyc();
    chk_out("ackpush_pre", 8'h02, 1'b1, 3'd0);
    drive(1'b1, 4'd6, 1'b1);
    cyc();
    chk_out("ackpush", 8'h20, 1'b1, 3'd0);
    drive(1'b0, 4'd0, 1'b1);
    cyc();
    chk_out("ackpush_end", 8'h00, 1'b0, 3'd0);
    drive(1'b0, 4'd0, 1'b0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
